fifo_wr_framer: RTL
===================

FIFO_WR_FRAMER -- requirements
Module: fifo_wr_framer

Interface
REQ-001 Parameter DATAWIDTH, default 8: width of stream data, datain and trailer.
REQ-002 Parameter MAX_LEN, default 64: maximum data bytes per packet, range 2..255.
REQ-003 wrclk  in  1  write-domain clock; all logic on the rising edge.
REQ-004 wrst  in  1  reset, asynchronous, active-low.
REQ-005 s_valid  in  1  upstream byte valid.
REQ-006 s_ready  out  1  block accepts the byte this cycle.
REQ-007 s_data  in  DATAWIDTH  upstream byte.
REQ-008 s_last  in  1  byte is the final data byte of a packet.
REQ-009 full  in  1  FIFO full flag, registered in the FIFO write domain.
REQ-010 w_en  out  1  FIFO write request; registered.
REQ-011 datain  out  DATAWIDTH  FIFO write data; registered.
REQ-012 pkt_cnt  out  16  count of packets whose final FIFO byte has been accepted; wraps 0xFFFF->0.
REQ-013 err_overlong  out  1  one-cycle pulse on a forced packet end.

Function
REQ-014 Input handshake fires when s_valid && s_ready; output handshake fires when w_en && !full.
REQ-015 The output stage is a single register (w_en, datain); it loads when it is empty (w_en=0) or its handshake fires in the same cycle.
REQ-016 Latency from input handshake to w_en=1 with that byte on datain is exactly 1 cycle.
REQ-017 w_en and datain hold stable while w_en=1 and full=1.
REQ-018 FSM states: DATA and TRAILER; reset state is DATA.
REQ-019 s_ready = (state==DATA) && (!w_en || !full); s_ready is combinational from full.
REQ-020 In DATA, each accepted byte XORs into the running checksum csum, and the byte counter len increments.
REQ-021 An accepted byte with s_last=1 moves the FSM DATA->TRAILER.
REQ-022 An accepted byte without s_last that makes len==MAX_LEN is a forced end: FSM moves to TRAILER, err_overlong pulses the next cycle, and the trailer is inverted.
REQ-023 In TRAILER, s_ready=0; the trailer (csum, or ~csum on a forced end) loads into the output register on the first cycle the output stage can load.
REQ-024 After the trailer loads: FSM returns to DATA, csum and len clear to 0, and the next packet may be accepted in the same cycle as the load completes.
REQ-025 pkt_cnt increments by 1 on the output handshake of the trailer byte.
REQ-026 The block never issues w_en for a byte other than a data byte or a trailer; there are no bubbles inserted while full=0 and s_valid=1, except the single trailer slot.
REQ-027 A packet of 1 byte (s_last on its first byte) is legal; its trailer equals that byte.

Reset
REQ-028 While wrst=0: w_en=0, datain=0, FSM=DATA, csum=0, len=0, pkt_cnt=0, err_overlong=0; s_ready therefore = 1.
REQ-029 A reset mid-packet discards the partial packet and any pending trailer; no trailer is emitted after reset release.

Configuration
REQ-030 Macro FIFO_WR_FRAMER_CHECKSUM_EN defined: trailer generation per REQ-020..REQ-025.
REQ-031 Macro undefined: no trailer and no TRAILER state; s_last and the forced end only close the packet, pkt_cnt increments on the output handshake of the final data byte, and err_overlong still pulses.

Structure
REQ-032 The shared package fifo_pkg holds the FSM state enum (DATA, TRAILER) and the default DATAWIDTH and MAX_LEN constants.
REQ-033 One sub-module, fifo_wr_outreg, implements the output register of REQ-015..REQ-017; the FSM, checksum and counters stay in the top.

Verification
REQ-034 Packet 0x11,0x22,0x33 (last on 0x33), full=0 -> FIFO bytes 0x11,0x22,0x33,0x00; pkt_cnt=1.
REQ-035 Packet 0xA5 alone -> FIFO bytes 0xA5,0xA5; there is one cycle with s_ready=0.
REQ-036 The bench drives full=1 for 5 cycles mid-packet -> w_en/datain hold; s_ready=0; no byte is lost or duplicated.
REQ-037 The bench sends 64 bytes of 0x01 with no s_last -> after byte 64, err_overlong pulses and the trailer is 0xFF.
REQ-038 The bench asserts wrst after 2 bytes of a packet, then sends 0x0F(last) -> FIFO bytes 0x0F,0x0F.
REQ-039 Without FIFO_WR_FRAMER_CHECKSUM_EN, packets are back-to-back -> no trailer bytes; s_ready stays 1 while full=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO write-side packet framer.
package fifo_pkg;
    localparam int DEF_DATAWIDTH = 8;
    localparam int DEF_MAX_LEN   = 64;

    typedef enum logic {
        DATA    = 1'b0,
        TRAILER = 1'b1
    } fr_state_e;
endpackage

// File: rtl/fifo_wr_outreg.sv
// Single-entry output register in front of the FIFO write port.
// Loads when empty or when its current byte is being taken this cycle;
// holds w_en/datain stable while the FIFO reports full.
module fifo_wr_outreg
    import fifo_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                 wrclk,
    input  logic                 wrst,
    input  logic                 full,
    input  logic                 in_vld,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_end,
    output logic                 can_load,
    output logic                 w_en,
    output logic [DATAWIDTH-1:0] datain,
    output logic                 end_flag
);

    assign can_load = !w_en || !full;

    // Output register: load on free slot, otherwise hold.
    always_ff @(posedge wrclk or negedge wrst) begin
        if (!wrst) begin
            w_en     <= 1'b0;
            datain   <= '0;
            end_flag <= 1'b0;
        end else if (can_load) begin
            w_en     <= in_vld;
            end_flag <= in_vld && in_end;
            if (in_vld) datain <= in_data;
        end
    end

endmodule

// File: rtl/fifo_wr_framer.sv
// Packet framer on the FIFO write side. Accepts a byte stream, forwards it
// through a single output register, and closes packets on s_last or on
// reaching MAX_LEN (forced end, flagged by err_overlong).
// Optional feature: define FIFO_WR_FRAMER_CHECKSUM_EN to append an XOR
// checksum trailer byte (inverted on a forced end) after each packet.
module fifo_wr_framer
    import fifo_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int MAX_LEN   = DEF_MAX_LEN
) (
    input  logic                 wrclk,
    input  logic                 wrst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATAWIDTH-1:0] s_data,
    input  logic                 s_last,
    input  logic                 full,
    output logic                 w_en,
    output logic [DATAWIDTH-1:0] datain,
    output logic [15:0]          pkt_cnt,
    output logic                 err_overlong
);

    localparam logic [7:0] LEN_LAST = 8'(MAX_LEN - 1);

    logic                 can_load;
    logic                 out_end;
    logic                 acc;
    logic                 at_limit;
    logic                 forced;
    logic                 pkt_close;
    logic                 out_vld;
    logic [DATAWIDTH-1:0] out_data;
    logic                 out_tag;
    logic [7:0]           len;

    assign acc       = s_valid && s_ready;
    assign at_limit  = (len == LEN_LAST);
    assign forced    = acc && !s_last && at_limit;
    assign pkt_close = acc && (s_last || at_limit);

`ifdef FIFO_WR_FRAMER_CHECKSUM_EN
    fr_state_e            state, state_nxt;
    logic [DATAWIDTH-1:0] csum;
    logic                 inv;

    assign s_ready = (state == DATA) && can_load;

    // State register plus checksum/length accumulation.
    always_ff @(posedge wrclk or negedge wrst) begin
        if (!wrst) begin
            state <= DATA;
            csum  <= '0;
            len   <= '0;
            inv   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                csum <= csum ^ s_data;
                len  <= len + 8'd1;
                if (pkt_close) inv <= forced;
            end
            if (state == TRAILER && can_load) begin
                csum <= '0;
                len  <= '0;
            end
        end
    end

    // Next state and output-stage feed: stream bytes in DATA, trailer in TRAILER.
    always_comb begin
        state_nxt = state;
        out_vld   = 1'b0;
        out_data  = s_data;
        out_tag   = 1'b0;
        case (state)
            DATA: begin
                out_vld = acc;
                if (pkt_close) state_nxt = TRAILER;
            end
            TRAILER: begin
                out_vld  = can_load;
                out_data = inv ? ~csum : csum;
                out_tag  = 1'b1;
                if (can_load) state_nxt = DATA;
            end
            default: state_nxt = DATA;
        endcase
    end
`else
    assign s_ready  = can_load;
    assign out_vld  = acc;
    assign out_data = s_data;
    assign out_tag  = pkt_close;

    // Length counter only; it restarts on every packet close.
    always_ff @(posedge wrclk or negedge wrst) begin
        if (!wrst)          len <= '0;
        else if (pkt_close) len <= '0;
        else if (acc)       len <= len + 8'd1;
    end
`endif

    fifo_wr_outreg #(.DATAWIDTH(DATAWIDTH)) u_outreg (
        .wrclk    (wrclk),
        .wrst     (wrst),
        .full     (full),
        .in_vld   (out_vld),
        .in_data  (out_data),
        .in_end   (out_tag),
        .can_load (can_load),
        .w_en     (w_en),
        .datain   (datain),
        .end_flag (out_end)
    );

    // Packet counter on the FIFO taking a packet's final byte; error pulse.
    always_ff @(posedge wrclk or negedge wrst) begin
        if (!wrst) begin
            pkt_cnt      <= '0;
            err_overlong <= 1'b0;
        end else begin
            err_overlong <= forced;
            if (w_en && !full && out_end) pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

endmodule
